// File: rtl/code_loader.sv
// Program loader: parses a 16-bit big-endian word count, then assembles
// big-endian instruction words from a byte stream and writes them to code memory.
module code_loader #(
    parameter int ADDR_W         = 9,
    parameter int MAX_WORDS      = 512,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              code_w_en,
    output logic [ADDR_W-1:0] code_addr_in,
    output logic [15:0]       code_in,
    output logic              run,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, RUN, ERR
    } state_t;

    state_t            state, next_state;
    logic [7:0]        len_hi;
    logic [15:0]       len;
    logic [7:0]        data_hi;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  idle_cnt;
    logic              started;

    logic              xfer;
    logic [15:0]       len_new;
    logic              len_bad;
    logic              last_word;
    logic              timed_out;
    logic              idle_state;

    assign xfer       = in_valid && in_ready;
    assign len_new    = {len_hi, in_data};
    assign len_bad    = (len_new == 16'd0) || (32'(len_new) > MAX_WORDS);
    assign last_word  = (32'(addr) == (32'(len) - 32'd1));
    assign timed_out  = (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign idle_state = (state == LEN_LO) || (state == DATA_HI) || (state == DATA_LO);

    // Next-state and Moore outputs; reload overrides everything, including a pending write.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        code_w_en  = 1'b0;
        run        = 1'b0;
        busy       = 1'b0;
        err        = 1'b0;
        case (state)
            LEN_HI: begin
                in_ready = 1'b1;
                busy     = started;
                if (xfer) next_state = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer)           next_state = len_bad ? ERR : DATA_HI;
                else if (timed_out) next_state = ERR;
            end
            DATA_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer)           next_state = DATA_LO;
                else if (timed_out) next_state = ERR;
            end
            DATA_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer)           next_state = WRITE;
                else if (timed_out) next_state = ERR;
            end
            WRITE: begin
                busy       = 1'b1;
                code_w_en  = 1'b1;
                next_state = last_word ? RUN : DATA_HI;
            end
            RUN:     run = 1'b1;
            ERR:     err = 1'b1;
            default: next_state = LEN_HI;
        endcase
        if (reload) begin
            next_state = LEN_HI;
            code_w_en  = 1'b0;
        end
    end

    // Datapath registers; write address/data are captured on the low-byte transfer
    // so they stay stable through WRITE and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LEN_HI;
            len_hi       <= '0;
            len          <= '0;
            data_hi      <= '0;
            addr         <= '0;
            idle_cnt     <= '0;
            started      <= 1'b0;
            words_loaded <= '0;
            code_addr_in <= '0;
            code_in      <= '0;
        end else begin
            state <= next_state;
            if (reload) begin
                addr         <= '0;
                words_loaded <= '0;
                idle_cnt     <= '0;
            end else begin
                if (xfer) begin
                    started  <= 1'b1;
                    idle_cnt <= '0;
                    case (state)
                        LEN_HI:  len_hi <= in_data;
                        LEN_LO: begin
                            len  <= len_new;
                            addr <= '0;
                        end
                        DATA_HI: data_hi <= in_data;
                        DATA_LO: begin
                            code_in      <= {data_hi, in_data};
                            code_addr_in <= addr;
                        end
                        default: ;
                    endcase
                end else if (idle_state) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end else begin
                    idle_cnt <= '0;
                end
                if (state == WRITE) begin
                    addr         <= addr + 1'b1;
                    words_loaded <= words_loaded + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_code_loader.sv
// Directed testbench for code_loader: header parsing, word assembly, timeout,
// reload abort and asynchronous reset, with a code memory model.
module tb_code_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        code_w_en;
    logic [8:0]  code_addr_in;
    logic [15:0] code_in;
    logic        run;
    logic        busy;
    logic        err;
    logic [9:0]  words_loaded;

    logic [15:0] mem [0:511];
    int          wr_count = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    code_loader #(
        .ADDR_W(9), .MAX_WORDS(512), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .code_w_en(code_w_en),
        .code_addr_in(code_addr_in), .code_in(code_in), .run(run),
        .busy(busy), .err(err), .words_loaded(words_loaded)
    );

    // Code memory model, sampled mid-cycle.
    always begin
        @(negedge clk);
        #1;
        if (code_w_en) begin
            mem[code_addr_in] = code_in;
            wr_count++;
        end
    end

    // Called at a negedge; holds the byte valid until accepted, returns at the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("[TB] FAIL send_byte_timeout: in_ready=%0b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (run !== 1'b0)        begin errors++; $display("[TB] FAIL reset_run: got %b want 0", run); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0)        begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err); end
        checks++; if (code_w_en !== 1'b0)  begin errors++; $display("[TB] FAIL reset_w_en: got %b want 0", code_w_en); end
        checks++; if (words_loaded !== 10'd0) begin errors++; $display("[TB] FAIL reset_words: got %0d want 0", words_loaded); end
        checks++; if (code_in !== 16'h0)   begin errors++; $display("[TB] FAIL reset_code_in: got %h want 0000", code_in); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        wr_count = 0;
        send_byte(8'h00); send_byte(8'h02);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b want 1", busy); end
        send_byte(8'h12); send_byte(8'h34);
        checks++; if ({code_w_en, code_addr_in, code_in} !== {1'b1, 9'd0, 16'h1234})
            begin errors++; $display("[TB] FAIL basic_write0: got en=%b a=%h d=%h want 1/000/1234", code_w_en, code_addr_in, code_in); end
        send_byte(8'hAB); send_byte(8'hCD);
        checks++; if ({code_w_en, code_addr_in, code_in} !== {1'b1, 9'd1, 16'hABCD})
            begin errors++; $display("[TB] FAIL basic_write1: got en=%b a=%h d=%h want 1/001/abcd", code_w_en, code_addr_in, code_in); end
        checks++; if (run !== 1'b0) begin errors++; $display("[TB] FAIL basic_run_early: got %b want 0", run); end
        @(negedge clk);
        #2;
        checks++; if ({run, busy, in_ready, code_w_en} !== 4'b1000)
            begin errors++; $display("[TB] FAIL basic_run: got run/busy/rdy/en=%b want 1000", {run, busy, in_ready, code_w_en}); end
        checks++; if (words_loaded !== 10'd2) begin errors++; $display("[TB] FAIL basic_words: got %0d want 2", words_loaded); end
        checks++; if ({mem[0], mem[1]} !== {16'h1234, 16'hABCD})
            begin errors++; $display("[TB] FAIL basic_mem: got %h %h want 1234 abcd", mem[0], mem[1]); end
        checks++; if (wr_count !== 2) begin errors++; $display("[TB] FAIL basic_wr_count: got %0d want 2", wr_count); end
    endtask

    task automatic test_bad_len();
        wr_count = 0;
        do_reload();
        checks++; if ({run, err} !== 2'b00) begin errors++; $display("[TB] FAIL badlen_reload_clear: got run/err=%b want 00", {run, err}); end
        send_byte(8'h00); send_byte(8'h00);
        checks++; if ({err, run, in_ready} !== 3'b100) begin errors++; $display("[TB] FAIL badlen_zero: got err/run/rdy=%b want 100", {err, run, in_ready}); end
        do_reload();
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL badlen_err_clear: got %b want 0", err); end
        send_byte(8'h02); send_byte(8'h01);
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL badlen_513: got err=%b want 1", err); end
        @(negedge clk);
        #2;
        checks++; if (wr_count !== 0) begin errors++; $display("[TB] FAIL badlen_no_write: got %0d writes want 0", wr_count); end
    endtask

    task automatic test_full();
        int bad = 0;
        wr_count = 0;
        do_reload();
        send_byte(8'h02); send_byte(8'h00);
        for (int i = 0; i < 512; i++) begin
            send_byte(8'(i >> 8));
            send_byte(8'(i));
        end
        checks++; if ({code_w_en, code_addr_in, code_in} !== {1'b1, 9'h1FF, 16'h01FF})
            begin errors++; $display("[TB] FAIL full_last_write: got en=%b a=%h d=%h want 1/1ff/01ff", code_w_en, code_addr_in, code_in); end
        @(negedge clk);
        #2;
        checks++; if (run !== 1'b1) begin errors++; $display("[TB] FAIL full_run: got %b want 1", run); end
        checks++; if (words_loaded !== 10'd512) begin errors++; $display("[TB] FAIL full_words: got %0d want 512", words_loaded); end
        checks++; if (wr_count !== 512) begin errors++; $display("[TB] FAIL full_wr_count: got %0d want 512", wr_count); end
        for (int i = 0; i < 512; i++) if (mem[i] !== 16'(i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL full_mem: got %0d bad words want 0", bad); end
    endtask

    task automatic test_timeout();
        do_reload();
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h00); send_byte(8'h07);
        repeat (10) @(negedge clk);
        checks++; if ({err, busy} !== 2'b01) begin errors++; $display("[TB] FAIL timeout_early: got err/busy=%b want 01", {err, busy}); end
        repeat (10) @(negedge clk);
        checks++; if ({err, run, in_ready} !== 3'b100) begin errors++; $display("[TB] FAIL timeout_err: got err/run/rdy=%b want 100", {err, run, in_ready}); end
        checks++; if (words_loaded !== 10'd1) begin errors++; $display("[TB] FAIL timeout_words: got %0d want 1", words_loaded); end
        do_reload();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF);
        @(negedge clk);
        #2;
        checks++; if ({run, err} !== 2'b10) begin errors++; $display("[TB] FAIL timeout_recover: got run/err=%b want 10", {run, err}); end
        checks++; if (mem[0] !== 16'hBEEF) begin errors++; $display("[TB] FAIL timeout_mem: got %h want beef", mem[0]); end
    endtask

    task automatic test_random_valid();
        logic [7:0] stream [0:9];
        stream = '{8'h00, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
        wr_count = 0;
        do_reload();
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(stream[i]);
        end
        @(negedge clk);
        #2;
        checks++; if ({run, words_loaded} !== {1'b1, 10'd4}) begin errors++; $display("[TB] FAIL rand_done: got run=%b words=%0d want 1/4", run, words_loaded); end
        checks++; if (wr_count !== 4) begin errors++; $display("[TB] FAIL rand_wr_count: got %0d want 4", wr_count); end
        checks++; if ({mem[0], mem[1], mem[2], mem[3]} !== {16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718})
            begin errors++; $display("[TB] FAIL rand_mem: got %h %h %h %h want a1b2 c3d4 e5f6 0718", mem[0], mem[1], mem[2], mem[3]); end
    endtask

    task automatic test_reload_abort();
        int wr_before;
        do_reload();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33);
        wr_before = wr_count;
        in_data  = 8'h44;
        in_valid = 1'b1;
        reload   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        reload   = 1'b0;
        checks++; if ({code_w_en, in_ready, run, err} !== 4'b0100)
            begin errors++; $display("[TB] FAIL abort_state: got en/rdy/run/err=%b want 0100", {code_w_en, in_ready, run, err}); end
        checks++; if (words_loaded !== 10'd0) begin errors++; $display("[TB] FAIL abort_words: got %0d want 0", words_loaded); end
        @(negedge clk);
        #2;
        checks++; if (wr_count !== wr_before) begin errors++; $display("[TB] FAIL abort_no_write: got %0d writes want %0d", wr_count, wr_before); end
        checks++; if (code_in !== 16'h1122) begin errors++; $display("[TB] FAIL abort_code_in: got %h want 1122", code_in); end
    endtask

    task automatic test_async_reset();
        int wr_before;
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h55); send_byte(8'h66);
        send_byte(8'h77);
        wr_before = wr_count;
        rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, busy, run, err, code_w_en} !== 5'b10000)
            begin errors++; $display("[TB] FAIL rst_mid_flags: got rdy/busy/run/err/en=%b want 10000", {in_ready, busy, run, err, code_w_en}); end
        checks++; if ({words_loaded, code_addr_in, code_in} !== {10'd0, 9'd0, 16'h0})
            begin errors++; $display("[TB] FAIL rst_mid_regs: got words=%0d a=%h d=%h want 0/000/0000", words_loaded, code_addr_in, code_in); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        checks++; if (wr_count !== wr_before) begin errors++; $display("[TB] FAIL rst_mid_no_write: got %0d writes want %0d", wr_count, wr_before); end
        checks++; if (mem[0] !== 16'h5566) begin errors++; $display("[TB] FAIL rst_mid_partial: got %h want 5566", mem[0]); end
        @(negedge clk);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hCA); send_byte(8'hFE);
        @(negedge clk);
        #2;
        checks++; if ({run, mem[0]} !== {1'b1, 16'hCAFE}) begin errors++; $display("[TB] FAIL rst_mid_reload: got run=%b mem0=%h want 1/cafe", run, mem[0]); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'hxxxx;
        @(negedge clk);
        test_reset();
        test_basic();
        test_bad_len();
        test_full();
        test_timeout();
        test_random_valid();
        test_reload_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
